// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS sequencing controller:
// state enum, opcode constants, ALUOp codes, mux select codes and
// small decode helpers used by both the controller and its output decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_R_EXEC    = 4'd3,
    ST_R_WB      = 4'd4,
    ST_I_EXEC    = 4'd5,
    ST_I_WB      = 4'd6,
    ST_MEM_ADDR  = 4'd7,
    ST_MEM_READ  = 4'd8,
    ST_MEM_WB    = 4'd9,
    ST_MEM_WRITE = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_JUMP      = 4'd12,
    ST_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_LUI   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b100;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Moore part of the control word; the fetch/branch Mealy terms are added in the top
  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } ctrl_t;

  // First execute-phase state for a freshly decoded opcode
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:                         return ST_R_EXEC;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: return ST_I_EXEC;
      OP_LW, OP_SW:                     return ST_MEM_ADDR;
      OP_BEQ, OP_BNE:                   return ST_BRANCH;
      OP_J:                             return ST_JUMP;
      default:                          return ST_TRAP;
    endcase
  endfunction

  // ALU operation for immediate-ALU instructions
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ORI:  return ALU_OR;
      OP_LUI:  return ALU_LUI;
      OP_ANDI: return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Unified instruction/data memory handshake seen by the controller.
// The controller (master) raises mem_req with the access type and holds
// it until the memory (slave) returns mem_ack for one cycle.
interface multicycle_control_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic mem_ack;

  modport master (output mem_req, output mem_read, output mem_write, input mem_ack);
  modport slave  (input mem_req, input mem_read, input mem_write, output mem_ack);
endinterface

// File: rtl/ctrl_out_decode.sv
// Purely combinational translation of controller state plus the latched
// opcode into the Moore part of the datapath control word.
module ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode_q,
  output ctrl_t      ctrl
);

  // Per-state control word; anything not named for a state stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      ST_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      ST_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(opcode_q);
      end
      ST_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_READ: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_en     = 1'b1;
      end
      ST_TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller. Owns the state register, the
// opcode latch captured at DECODE and the next-state logic; the per-state
// control word comes from ctrl_out_decode, with the fetch-ack and branch
// resolution terms of pc_en/ir_write added here combinationally.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        mem,
  input  logic [5:0]                  opcode,
  input  logic                        zero,
  output logic                        i_or_d,
  output logic                        ir_write,
  output logic                        pc_en,
  output logic [1:0]                  pc_source,
  output logic                        alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [2:0]                  alu_op,
  output logic                        reg_dst,
  output logic                        mem_to_reg,
  output logic                        reg_write,
  output logic                        illegal_op,
  output logic [3:0]                  state_dbg
);

  state_t     state;
  state_t     state_next;
  logic [5:0] opcode_q;
  ctrl_t      ctrl;
  logic       fetch_done;
  logic       branch_taken;

  // State register and opcode latch; the opcode is only trusted at DECODE
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      opcode_q <= '0;
    end else begin
      state <= state_next;
      if (state == ST_DECODE) opcode_q <= opcode;
    end
  end

  // Next-state selection; memory states wait for the ack, TRAP only leaves via reset
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      state_next = ST_FETCH;
      ST_FETCH:     if (mem.mem_ack) state_next = ST_DECODE;
      ST_DECODE:    state_next = decode_target(opcode);
      ST_R_EXEC:    state_next = ST_R_WB;
      ST_R_WB:      state_next = ST_FETCH;
      ST_I_EXEC:    state_next = ST_I_WB;
      ST_I_WB:      state_next = ST_FETCH;
      ST_MEM_ADDR:  state_next = (opcode_q == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem.mem_ack) state_next = ST_MEM_WB;
      ST_MEM_WB:    state_next = ST_FETCH;
      ST_MEM_WRITE: if (mem.mem_ack) state_next = ST_FETCH;
      ST_BRANCH:    state_next = ST_FETCH;
      ST_JUMP:      state_next = ST_FETCH;
      ST_TRAP:      state_next = ST_TRAP;
      default:      state_next = ST_IDLE;
    endcase
  end

  ctrl_out_decode u_decode (
    .state    (state),
    .opcode_q (opcode_q),
    .ctrl     (ctrl)
  );

  assign fetch_done   = (state == ST_FETCH) && mem.mem_ack;
  assign branch_taken = (state == ST_BRANCH) && ((opcode_q == OP_BNE) ? !zero : zero);

  assign mem.mem_req   = ctrl.mem_req;
  assign mem.mem_read  = ctrl.mem_read;
  assign mem.mem_write = ctrl.mem_write;

  assign i_or_d     = ctrl.i_or_d;
  assign ir_write   = fetch_done;
  assign pc_en      = ctrl.pc_en | fetch_done | branch_taken;
  assign pc_source  = ctrl.pc_source;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign illegal_op = ctrl.illegal_op;
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. An instruction-level model
// (per-opcode step plan plus a per-step output table) predicts every
// output each cycle; literal checks in the stimulus pin latencies and
// key control values.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam logic [5:0] XOP = 6'b111110;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       i_or_d, ir_write, pc_en, alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;

  multicycle_control_if mem_bus();

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (mem_bus),
    .opcode     (opcode),
    .zero       (zero),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_source  (pc_source),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic [3:0] state;
  } obs_t;

  int     total_checks = 0;
  int     passed_checks = 0;
  bit     m_valid = 0;
  bit     done = 0;
  state_t m_cur = ST_IDLE;
  logic [5:0] m_op = '0;
  state_t m_plan[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs for one step of an instruction, straight from the state table
  function automatic obs_t expect_obs(input state_t s, input logic [5:0] op,
                                      input logic ack, input logic z);
    obs_t e;
    e = '0;
    e.state = s;
    case (s)
      ST_FETCH:     begin e.mem_req = 1; e.mem_read = 1; e.alu_src_b = 2'b01;
                          e.ir_write = ack; e.pc_en = ack; end
      ST_DECODE:    e.alu_src_b = 2'b11;
      ST_R_EXEC:    begin e.alu_src_a = 1; e.alu_op = 3'b111; end
      ST_R_WB:      begin e.reg_dst = 1; e.reg_write = 1; end
      ST_I_EXEC:    begin e.alu_src_a = 1; e.alu_src_b = 2'b10;
                          e.alu_op = (op == 6'b001101) ? 3'b001 :
                                     (op == 6'b001111) ? 3'b010 :
                                     (op == 6'b001100) ? 3'b011 : 3'b000; end
      ST_I_WB:      e.reg_write = 1;
      ST_MEM_ADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      ST_MEM_READ:  begin e.mem_req = 1; e.mem_read = 1; e.i_or_d = 1; end
      ST_MEM_WB:    begin e.mem_to_reg = 1; e.reg_write = 1; end
      ST_MEM_WRITE: begin e.mem_req = 1; e.mem_write = 1; e.i_or_d = 1; end
      ST_BRANCH:    begin e.alu_src_a = 1; e.alu_op = 3'b100; e.pc_source = 2'b01;
                          e.pc_en = (op == 6'b000100) ? z : !z; end
      ST_JUMP:      begin e.pc_source = 2'b10; e.pc_en = 1; end
      ST_TRAP:      e.illegal_op = 1;
      default:      e.state = s;
    endcase
    return e;
  endfunction

  // Remaining steps of an instruction once its opcode is known
  task automatic plan_instruction(input logic [5:0] op);
    case (op)
      6'b000000:                          begin m_plan.push_back(ST_R_EXEC); m_plan.push_back(ST_R_WB); end
      6'b001000, 6'b001100, 6'b001101,
      6'b001111:                          begin m_plan.push_back(ST_I_EXEC); m_plan.push_back(ST_I_WB); end
      6'b100011:                          begin m_plan.push_back(ST_MEM_ADDR); m_plan.push_back(ST_MEM_READ);
                                                m_plan.push_back(ST_MEM_WB); end
      6'b101011:                          begin m_plan.push_back(ST_MEM_ADDR); m_plan.push_back(ST_MEM_WRITE); end
      6'b000100, 6'b000101:               m_plan.push_back(ST_BRANCH);
      6'b000010:                          m_plan.push_back(ST_JUMP);
      default:                            m_plan.push_back(ST_TRAP);
    endcase
  endtask

  task automatic advance();
    if (m_plan.size() > 0) m_cur = m_plan.pop_front();
    else m_cur = ST_FETCH;
  endtask

  // Model update once per rising edge, using the inputs of the cycle just ended
  task automatic model_step();
    if (!reset) begin
      m_cur = ST_IDLE;
      m_plan.delete();
      m_valid = 1;
    end else begin
      case (m_cur)
        ST_IDLE:  m_cur = ST_FETCH;
        ST_TRAP:  m_cur = ST_TRAP;
        ST_FETCH: if (mem_bus.mem_ack) begin m_plan.delete(); m_cur = ST_DECODE; end
        ST_MEM_READ, ST_MEM_WRITE: if (mem_bus.mem_ack) advance();
        ST_DECODE: begin m_op = opcode; plan_instruction(opcode); advance(); end
        default:  advance();
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial begin
    obs_t exp_o, act_o;
    forever begin
      @(negedge clk);
      if (m_valid && !done) begin
        exp_o = expect_obs(m_cur, m_op, mem_bus.mem_ack, zero);
        act_o = {mem_bus.mem_req, mem_bus.mem_read, mem_bus.mem_write, i_or_d, ir_write, pc_en,
                 pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
                 illegal_op, state_dbg};
        total_checks++;
        if (act_o === exp_o) passed_checks++;
        else $display("[TB] FAIL model_outputs t=%0t actual=%h expected=%h", $time, act_o, exp_o);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic z, input logic a);
    @(posedge clk);
    #1;
    reset = r;
    opcode = op;
    zero = z;
    mem_bus.mem_ack = a;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
  endtask

  initial begin
    logic [5:0] iops [4];
    logic [2:0] iexp [4];
    iops = '{6'b001101, 6'b001100, 6'b001111, 6'b001000};
    iexp = '{3'b001, 3'b011, 3'b010, 3'b000};

    reset = 1'b0;
    opcode = 6'b000000;
    zero = 1'b0;
    mem_bus.mem_ack = 1'b0;

    $display("[TB] reset and R-type");
    applyStimulus(0, 6'b000000, 0, 1);
    applyStimulus(0, 6'b000000, 0, 1);
    applyStimulus(1, 6'b000000, 0, 1);
    checkOutput("idle_state", state_dbg, 0);
    checkOutput("idle_mem_req", mem_bus.mem_req, 0);
    checkOutput("idle_illegal", illegal_op, 0);
    applyStimulus(1, 6'b000000, 0, 1);
    checkOutput("r_fetch_state", state_dbg, 1);
    checkOutput("r_fetch_ir_write", ir_write, 1);
    checkOutput("r_fetch_pc_en", pc_en, 1);
    applyStimulus(1, 6'b000000, 0, 1);
    checkOutput("r_decode_srcb", alu_src_b, 2'b11);
    applyStimulus(1, 6'b000000, 0, 0);
    checkOutput("r_exec_alu_op", alu_op, 3'b111);
    applyStimulus(1, XOP, 0, 0);
    checkOutput("r_wb_reg_write", reg_write, 1);
    checkOutput("r_wb_reg_dst", reg_dst, 1);

    $display("[TB] LW with three wait cycles on fetch and read");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, XOP, 0, 0);
      checkOutput("lw_fetch_wait_state", state_dbg, 1);
      checkOutput("lw_fetch_wait_req", mem_bus.mem_req, 1);
      checkOutput("lw_fetch_wait_ir_write", ir_write, 0);
    end
    applyStimulus(1, XOP, 0, 1);
    checkOutput("lw_fetch_ack_ir_write", ir_write, 1);
    applyStimulus(1, 6'b100011, 0, 0);
    applyStimulus(1, XOP, 0, 0);
    checkOutput("lw_addr_srcb", alu_src_b, 2'b10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, XOP, 0, 0);
      checkOutput("lw_read_wait_req", mem_bus.mem_req, 1);
      checkOutput("lw_read_wait_read", mem_bus.mem_read, 1);
      checkOutput("lw_read_wait_i_or_d", i_or_d, 1);
    end
    applyStimulus(1, XOP, 0, 1);
    applyStimulus(1, XOP, 0, 1);
    checkOutput("lw_wb_mem_to_reg", mem_to_reg, 1);
    checkOutput("lw_wb_reg_write", reg_write, 1);
    checkOutput("lw_wb_mem_req", mem_bus.mem_req, 0);

    $display("[TB] branches");
    applyStimulus(1, XOP, 0, 1);
    checkOutput("lw_eleven_cycles", state_dbg, 1);
    applyStimulus(1, 6'b000100, 0, 0);
    applyStimulus(1, XOP, 1, 0);
    checkOutput("beq_taken_pc_en", pc_en, 1);
    checkOutput("beq_pc_source", pc_source, 2'b01);
    checkOutput("beq_alu_op", alu_op, 3'b100);
    applyStimulus(1, XOP, 0, 1);
    checkOutput("beq_three_cycles", state_dbg, 1);
    applyStimulus(1, 6'b000101, 0, 0);
    applyStimulus(1, XOP, 1, 0);
    checkOutput("bne_not_taken_pc_en", pc_en, 0);
    checkOutput("bne_pc_source", pc_source, 2'b01);
    checkOutput("bne_alu_op", alu_op, 3'b100);
    applyStimulus(1, XOP, 0, 1);
    applyStimulus(1, 6'b000101, 1, 0);
    applyStimulus(1, XOP, 0, 0);
    checkOutput("bne_taken_pc_en", pc_en, 1);
    applyStimulus(1, XOP, 0, 1);
    applyStimulus(1, 6'b000100, 1, 0);
    applyStimulus(1, XOP, 0, 0);
    checkOutput("beq_not_taken_pc_en", pc_en, 0);

    $display("[TB] immediate ALU instructions");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, XOP, 0, 1);
      applyStimulus(1, iops[k], 0, 0);
      applyStimulus(1, XOP, 0, 0);
      checkOutput("i_exec_alu_op", alu_op, iexp[k]);
      applyStimulus(1, XOP, 0, 0);
      checkOutput("i_wb_reg_dst", reg_dst, 0);
      checkOutput("i_wb_reg_write", reg_write, 1);
    end

    $display("[TB] jump and zero-wait store");
    applyStimulus(1, XOP, 0, 1);
    applyStimulus(1, 6'b000010, 0, 0);
    applyStimulus(1, XOP, 0, 0);
    checkOutput("j_pc_en", pc_en, 1);
    checkOutput("j_pc_source", pc_source, 2'b10);
    applyStimulus(1, XOP, 0, 1);
    applyStimulus(1, 6'b101011, 0, 0);
    applyStimulus(1, XOP, 0, 0);
    applyStimulus(1, XOP, 0, 1);
    checkOutput("sw_mem_write", mem_bus.mem_write, 1);
    checkOutput("sw_mem_read", mem_bus.mem_read, 0);

    $display("[TB] reset during store wait");
    applyStimulus(1, XOP, 0, 1);
    checkOutput("sw_four_cycles", state_dbg, 1);
    applyStimulus(1, 6'b101011, 0, 0);
    applyStimulus(1, XOP, 0, 0);
    applyStimulus(1, XOP, 0, 0);
    checkOutput("sw_wait_mem_write", mem_bus.mem_write, 1);
    applyStimulus(0, XOP, 0, 0);
    applyStimulus(0, XOP, 0, 1);
    checkOutput("rst_mid_state", state_dbg, 0);
    checkOutput("rst_mid_mem_write", mem_bus.mem_write, 0);
    checkOutput("rst_mid_mem_req", mem_bus.mem_req, 0);
    applyStimulus(1, XOP, 0, 0);
    checkOutput("late_ack_state", state_dbg, 0);

    $display("[TB] illegal opcode trap");
    applyStimulus(1, XOP, 0, 1);
    checkOutput("trap_fetch_state", state_dbg, 1);
    applyStimulus(1, 6'b111111, 0, 1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, 6'(k), k[0], 1'(k % 3 == 0));
      checkOutput("trap_illegal", illegal_op, 1);
      checkOutput("trap_mem_req", mem_bus.mem_req, 0);
    end
    applyStimulus(0, XOP, 0, 0);
    applyStimulus(1, XOP, 0, 1);
    checkOutput("trap_reset_illegal", illegal_op, 0);
    checkOutput("trap_reset_state", state_dbg, 0);
    applyStimulus(1, XOP, 0, 1);
    checkOutput("trap_restart_fetch", state_dbg, 1);
    applyStimulus(1, 6'b000000, 0, 0);
    applyStimulus(1, XOP, 0, 0);

    done = 1;
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
